pc_sequencer: RTL

- Parametrised program-counter sequencer for the freedom_core fetch stage. It is the next generation of the single-width PC register.
- Computes the next PC internally from an increment, branch/ALU target or restart vector.
- Validates every candidate PC against alignment and the instruction-memory window before committing it.
- Runs a small RUN/TRAP/HALT state machine with fault capture, stall support and a saturating fault counter.

---
 rtl/pc_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: computes, validates and commits the next PC, with RUN/HALT (or TRAP) fault handling.
// Latency: one cycle from candidate select to pc. Backpressure: stall holds pc and fault state, HALT holds until restart.
// Optional trap redirect (one TRAP cycle at TRAP_VECTOR instead of HALT) is compiled in with PC_TRAP_REDIRECT_EN.
module pc_sequencer #(
    parameter int unsigned           XLEN         = 32,
    parameter logic [XLEN-1:0]       RESET_VECTOR = 32'h0100_0000,
    parameter logic [XLEN-1:0]       IMEM_BASE    = 32'h0100_0000,
    parameter logic [XLEN-1:0]       IMEM_LIMIT   = 32'h0100_0FFC,
    parameter int unsigned           INC          = 4,
    parameter int unsigned           ALIGN_BITS   = 2,
    parameter logic [XLEN-1:0]       TRAP_VECTOR  = 32'h0100_0F00,
    parameter int unsigned           CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             restart,
    input  logic [1:0]       pc_sel,
    input  logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             halt,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] fault_count
);

    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_RANGE = 2'b10;
    localparam logic [1:0] CAUSE_SEL   = 2'b11;

`ifdef PC_TRAP_REDIRECT_EN
    typedef enum logic [1:0] {S_RUN, S_HALT, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_RUN, S_HALT} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] cand;
    logic [1:0]      cand_cause;
    logic            cand_bad;

    // For an illegal select the candidate is the current pc so it lands in fault_addr.
    always_comb begin
        cand       = pc;
        cand_cause = CAUSE_NONE;
        case (pc_sel)
            2'b00:   cand = target;
            2'b01:   cand = pc + INC_X;
            2'b10:   cand = RESET_VECTOR;
            default: cand = pc;
        endcase
        if (pc_sel == 2'b11) begin
            cand_cause = CAUSE_SEL;
        end else if ((cand & ALIGN_MASK) != '0) begin
            cand_cause = CAUSE_ALIGN;
        end else if ((cand < IMEM_BASE) || (cand > IMEM_LIMIT)) begin
            cand_cause = CAUSE_RANGE;
        end
        cand_bad = (cand_cause != CAUSE_NONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            pc          <= RESET_VECTOR;
            pc_valid    <= 1'b1;
            halt        <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            fault_addr  <= '0;
            fault_count <= '0;
        end else begin
            fault <= 1'b0;
            case (state)
                S_RUN: begin
                    if (restart) begin
                        pc          <= RESET_VECTOR;
                        pc_valid    <= 1'b1;
                        halt        <= 1'b0;
                        fault_cause <= CAUSE_NONE;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (!cand_bad) begin
                        pc <= cand;
                    end else begin
                        fault       <= 1'b1;
                        fault_cause <= cand_cause;
                        fault_addr  <= cand;
                        pc_valid    <= 1'b0;
                        if (fault_count != '1) begin
                            fault_count <= fault_count + 1'b1;
                        end
`ifdef PC_TRAP_REDIRECT_EN
                        state <= S_TRAP;
                        pc    <= TRAP_VECTOR;
`else
                        state <= S_HALT;
                        halt  <= 1'b1;
`endif
                    end
                end
                S_HALT: begin
                    if (restart) begin
                        state       <= S_RUN;
                        pc          <= RESET_VECTOR;
                        pc_valid    <= 1'b1;
                        halt        <= 1'b0;
                        fault_cause <= CAUSE_NONE;
                    end
                end
`ifdef PC_TRAP_REDIRECT_EN
                // The redirect cannot be stalled; only restart overrides it.
                S_TRAP: begin
                    state    <= S_RUN;
                    pc_valid <= 1'b1;
                    if (restart) begin
                        pc          <= RESET_VECTOR;
                        fault_cause <= CAUSE_NONE;
                    end
                end
`endif
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

endmodule
